// File: rtl/gmrr_addr_gen_if.sv
// AXI-Stream address channel between gmrr_addr_gen and the coefficient RAM read side.
// Carries the integer address, the fractional phase sideband and the handshake.
interface gmrr_addr_gen_if #(
  parameter int AWIDTH = 10,
  parameter int FWIDTH = 16
);
  logic [AWIDTH-1:0] o_tdata;
  logic [FWIDTH-1:0] o_frac;
  logic              o_tlast;
  logic              o_tvalid;
  logic              o_tready;

  modport master (
    output o_tdata, o_frac, o_tlast, o_tvalid,
    input  o_tready
  );

  modport slave (
    input  o_tdata, o_frac, o_tlast, o_tvalid,
    output o_tready
  );
endinterface

// File: rtl/gmrr_addr_gen.sv
// Phase-accumulator address generator: emits cfg_len RAM addresses per go as an AXI-Stream burst.
// Optional feature macro GMRR_ADDR_GEN_FRAC_EN: truncated address plus fractional sideband
// (default build rounds the address to nearest and ties o_frac to zero).
module gmrr_addr_gen #(
  parameter int AWIDTH = 10,
  parameter int FWIDTH = 16,
  parameter int LWIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     clear,
  input  logic [AWIDTH+FWIDTH-1:0] cfg_start,
  input  logic [AWIDTH+FWIDTH-1:0] cfg_step,
  input  logic [LWIDTH-1:0]        cfg_len,
  input  logic                     go,
  output logic                     busy,
  gmrr_addr_gen_if.master          o_axis
);

  localparam int PW = AWIDTH + FWIDTH;

  typedef enum logic {IDLE, RUN} state_t;

  state_t            r_state, w_state_nxt;
  logic [PW-1:0]     r_acc, r_step, w_acc_nxt;
  logic [LWIDTH-1:0] r_cnt;
  logic [AWIDTH-1:0] r_tdata, w_addr_nxt;
  logic              w_rst, w_run, w_last, w_beat, w_go_ok, w_load;

  assign w_rst   = !reset_n || clear;
  assign w_run   = (r_state == RUN);
  assign w_last  = (r_cnt == LWIDTH'(1));
  assign w_beat  = w_run && o_axis.o_tready;
  assign w_go_ok = go && (cfg_len != '0);
  // A go is taken from IDLE, or on the completing last beat so bursts chain without a gap.
  assign w_load  = w_go_ok && (!w_run || (w_beat && w_last));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (w_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_go_ok) w_state_nxt = RUN;
      RUN:  if (w_beat && w_last) w_state_nxt = w_go_ok ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy            = 1'b0;
    o_axis.o_tvalid = 1'b0;
    o_axis.o_tlast  = 1'b0;
    if (r_state == RUN) begin
      busy            = 1'b1;
      o_axis.o_tvalid = 1'b1;
      o_axis.o_tlast  = w_last;
    end
  end

  // Accumulator holds the phase of the beat currently presented; it moves only on load or beat.
  always_comb begin
    w_acc_nxt = r_acc;
    if (w_load)      w_acc_nxt = cfg_start;
    else if (w_beat) w_acc_nxt = r_acc + r_step;
  end

`ifdef GMRR_ADDR_GEN_FRAC_EN
  logic [FWIDTH-1:0] r_frac;

  assign w_addr_nxt   = w_acc_nxt[PW-1:FWIDTH];
  assign o_axis.o_frac = r_frac;

  always_ff @(posedge clk) begin
    if (w_rst)                r_frac <= '0;
    else if (w_load || w_beat) r_frac <= w_acc_nxt[FWIDTH-1:0];
  end
`else
  localparam logic [PW-1:0] HALF = PW'(1) << (FWIDTH - 1);

  // Round to nearest; the phase-width add wraps, so the top bits wrap modulo 2^AWIDTH.
  assign w_addr_nxt    = AWIDTH'((w_acc_nxt + HALF) >> FWIDTH);
  assign o_axis.o_frac = '0;
`endif

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_acc   <= '0;
      r_step  <= '0;
      r_cnt   <= '0;
      r_tdata <= '0;
    end else begin
      if (w_load) begin
        r_step <= cfg_step;
        r_cnt  <= cfg_len;
      end else if (w_beat) begin
        r_cnt  <= r_cnt - LWIDTH'(1);
      end
      if (w_load || w_beat) begin
        r_acc   <= w_acc_nxt;
        r_tdata <= w_addr_nxt;
      end
    end
  end

  assign o_axis.o_tdata = r_tdata;

endmodule

// File: tb/tb_gmrr_addr_gen.sv
// Scoreboard bench for gmrr_addr_gen: directed bursts push expected beats, a monitor pops and compares.
module tb_gmrr_addr_gen;

  localparam int AW = 10;
  localparam int FW = 16;
  localparam int LW = 16;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [FW-1:0] frac;
    logic          last;
  } exp_t;

  logic           clk = 1'b0;
  logic           reset_n, clear, go, busy;
  logic [AW+FW-1:0] cfg_start, cfg_step;
  logic [LW-1:0]  cfg_len;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  gmrr_addr_gen_if #(.AWIDTH(AW), .FWIDTH(FW)) axis ();

  gmrr_addr_gen #(.AWIDTH(AW), .FWIDTH(FW), .LWIDTH(LW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .clear     (clear),
    .cfg_start (cfg_start),
    .cfg_step  (cfg_step),
    .cfg_len   (cfg_len),
    .go        (go),
    .busy      (busy),
    .o_axis    (axis.master)
  );

  always #5 clk = ~clk;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [AW-1:0] a, input logic [FW-1:0] f, input logic l);
    exp_t e;
    e.addr = a;
    e.frac = f;
    e.last = l;
    sb.push_back(e);
  endfunction

  // Monitor: scoreboard pops on each beat, plus hold checks on every stalled cycle.
  initial begin
    logic          prev_stall;
    logic [AW-1:0] prev_data;
    logic [FW-1:0] prev_frac;
    logic          prev_last;
    exp_t          e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_frac  = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_stall) begin
        check(axis.o_tvalid === 1'b1, "stall_valid_hold", 32'(axis.o_tvalid), 32'd1);
        check(axis.o_tdata === prev_data, "stall_data_hold", 32'(axis.o_tdata), 32'(prev_data));
        check(axis.o_frac === prev_frac, "stall_frac_hold", 32'(axis.o_frac), 32'(prev_frac));
        check(axis.o_tlast === prev_last, "stall_last_hold", 32'(axis.o_tlast), 32'(prev_last));
      end
      if (axis.o_tvalid === 1'b1 && axis.o_tready === 1'b1) begin
        if (sb.size() == 0) begin
          check(1'b0, "unexpected_beat", 32'(axis.o_tdata), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check(axis.o_tdata === e.addr, "beat_addr", 32'(axis.o_tdata), 32'(e.addr));
          check(axis.o_frac === e.frac, "beat_frac", 32'(axis.o_frac), 32'(e.frac));
          check(axis.o_tlast === e.last, "beat_last", 32'(axis.o_tlast), 32'(e.last));
        end
      end
      prev_stall = (axis.o_tvalid === 1'b1) && (axis.o_tready === 1'b0);
      prev_data  = axis.o_tdata;
      prev_frac  = axis.o_frac;
      prev_last  = axis.o_tlast;
    end
  end

  // Called just after a rising edge; go is seen by the DUT on the next rising edge.
  task automatic launch(input logic [AW+FW-1:0] s, input logic [AW+FW-1:0] st, input logic [LW-1:0] l);
    go        = 1'b1;
    cfg_start = s;
    cfg_step  = st;
    cfg_len   = l;
    @(posedge clk);
    #1;
    go        = 1'b0;
    cfg_start = '1;
    cfg_step  = '1;
    cfg_len   = '0;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(negedge clk);
      if (busy === 1'b0) done = 1'b1;
    end
    check(done, {name, "_idle_timeout"}, 32'(busy), 32'd0);
    check(sb.size() == 0, {name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic abort_burst(input bit use_clear, input string name);
    launch(26'h2_0000, 26'h1_0000, 16'd8);
    push(10'd2, '0, 1'b0);
    push(10'd3, '0, 1'b0);
    @(posedge clk);
    #1;
    if (use_clear) clear = 1'b1;
    else           reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check(axis.o_tvalid === 1'b0, {name, "_tvalid"}, 32'(axis.o_tvalid), 32'd0);
    check(axis.o_tlast === 1'b0, {name, "_tlast"}, 32'(axis.o_tlast), 32'd0);
    check(busy === 1'b0, {name, "_busy"}, 32'(busy), 32'd0);
    check(axis.o_tdata === '0, {name, "_tdata"}, 32'(axis.o_tdata), 32'd0);
    #1;
    clear   = 1'b0;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check(sb.size() == 0, {name, "_sb_drained"}, 32'(sb.size()), 32'd0);
    launch(26'h7_0000, 26'h1_0000, 16'd2);
    push(10'd7, '0, 1'b0);
    push(10'd8, '0, 1'b1);
    wait_idle({name, "_fresh"});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    reset_n        = 1'b0;
    clear          = 1'b0;
    go             = 1'b0;
    cfg_start      = '0;
    cfg_step       = '0;
    cfg_len        = '0;
    axis.o_tready  = 1'b1;

    // Reset state
    @(posedge clk);
    @(negedge clk);
    check(axis.o_tvalid === 1'b0, "rst_tvalid", 32'(axis.o_tvalid), 32'd0);
    check(axis.o_tlast === 1'b0, "rst_tlast", 32'(axis.o_tlast), 32'd0);
    check(busy === 1'b0, "rst_busy", 32'(busy), 32'd0);
    check(axis.o_tdata === '0, "rst_tdata", 32'(axis.o_tdata), 32'd0);
    check(axis.o_frac === '0, "rst_frac", 32'(axis.o_frac), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic burst 0,1,2,3; busy low the cycle after the last beat
    launch(26'h0, 26'h1_0000, 16'd4);
    push(10'd0, '0, 1'b0);
    push(10'd1, '0, 1'b0);
    push(10'd2, '0, 1'b0);
    push(10'd3, '0, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check(busy === 1'b0, "basic_busy_after", 32'(busy), 32'd0);
    check(axis.o_tvalid === 1'b0, "basic_tvalid_after", 32'(axis.o_tvalid), 32'd0);
    wait_idle("basic");

    // Half-sample step
    launch(26'h0, 26'h0_8000, 16'd3);
`ifdef GMRR_ADDR_GEN_FRAC_EN
    push(10'd0, 16'h0000, 1'b0);
    push(10'd0, 16'h8000, 1'b0);
    push(10'd1, 16'h0000, 1'b1);
`else
    push(10'd0, 16'h0000, 1'b0);
    push(10'd1, 16'h0000, 1'b0);
    push(10'd1, 16'h0000, 1'b1);
`endif
    wait_idle("frac");

    // Address wrap 1023 -> 0 -> 1
    launch(26'h3FF_0000, 26'h1_0000, 16'd3);
    push(10'd1023, '0, 1'b0);
    push(10'd0, '0, 1'b0);
    push(10'd1, '0, 1'b1);
    wait_idle("wrap");

    // Zero step repeats the start address; single-beat rounding of 1.5
    launch(26'h3_0000, 26'h0, 16'd3);
    push(10'd3, '0, 1'b0);
    push(10'd3, '0, 1'b0);
    push(10'd3, '0, 1'b1);
    wait_idle("step0");
    launch(26'h1_8000, 26'h0, 16'd1);
`ifdef GMRR_ADDR_GEN_FRAC_EN
    push(10'd1, 16'h8000, 1'b1);
`else
    push(10'd2, 16'h0000, 1'b1);
`endif
    wait_idle("len1_round");

    // Backpressure 1,0,0,1 with a go during the stall that must be ignored
    launch(26'h5_0000, 26'h1_0000, 16'd4);
    push(10'd5, '0, 1'b0);
    push(10'd6, '0, 1'b0);
    push(10'd7, '0, 1'b0);
    push(10'd8, '0, 1'b1);
    @(posedge clk);
    #1;
    axis.o_tready = 1'b0;
    go            = 1'b1;
    cfg_start     = 26'h99_0000;
    cfg_step      = 26'h1_0000;
    cfg_len       = 16'd5;
    @(posedge clk);
    #1;
    go            = 1'b0;
    cfg_len       = '0;
    @(posedge clk);
    #1;
    axis.o_tready = 1'b1;
    wait_idle("bp");

    // go with len=0 is ignored
    launch(26'h4_0000, 26'h1_0000, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check(busy === 1'b0, "len0_busy", 32'(busy), 32'd0);
      check(axis.o_tvalid === 1'b0, "len0_tvalid", 32'(axis.o_tvalid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Abort by reset and by clear, then a fresh burst each time
    abort_burst(1'b0, "rst_abort");
    abort_burst(1'b1, "clr_abort");

    // Back-to-back: go on the last beat, next burst first address the following cycle
    launch(26'hA_0000, 26'h1_0000, 16'd2);
    push(10'd10, '0, 1'b0);
    push(10'd11, '0, 1'b1);
    push(10'd20, '0, 1'b0);
    push(10'd21, '0, 1'b1);
    @(posedge clk);
    #1;
    go        = 1'b1;
    cfg_start = 26'h14_0000;
    cfg_step  = 26'h1_0000;
    cfg_len   = 16'd2;
    @(posedge clk);
    #1;
    go        = 1'b0;
    cfg_len   = '0;
    @(negedge clk);
    check(axis.o_tvalid === 1'b1, "b2b_tvalid", 32'(axis.o_tvalid), 32'd1);
    check(axis.o_tdata === 10'd20, "b2b_first_addr", 32'(axis.o_tdata), 32'd20);
    @(posedge clk);
    #1;
    wait_idle("b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
